// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of MemControl: one transaction at a time, IDLE -> ACCESS -> RESP.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed M0 priority (with MAX_BURST bound) by alternation.
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // Handshake: a master raises req with we/addr/wdata stable and holds them until its
    // 1-cycle ack; it must drop req (or present a new request) in the cycle after ack.
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            grant,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic [DATA_WIDTH-1:0] r_m1_rdata;
    logic                  w_any_req;
    logic                  w_pick_m1;
    logic                  w_start;

    assign w_any_req = m0_req | m1_req;
    assign w_start   = (r_state == ST_IDLE) && w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
    // r_owner remembers the last winner, so on a tie the other master goes next.
    assign w_pick_m1 = m1_req & (~m0_req | ~r_owner);
`else
    localparam int                 CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] r_burst_cnt;

    // M0 wins ties until it has taken MAX_BURST grants in a row against a waiting M1.
    assign w_pick_m1 = m1_req & (~m0_req | (r_burst_cnt == BURST_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (!m1_req || w_pick_m1) begin
                r_burst_cnt <= '0;
            end else if (m0_req && (r_burst_cnt != BURST_MAX)) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_owner <= w_pick_m1;
            r_we    <= w_pick_m1 ? m1_we    : m0_we;
            r_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
            r_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
        end
    end

    // Read data is taken from MemControl at the end of ACCESS, while mem_addr is still driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if ((r_state == ST_ACCESS) && !r_we) begin
            if (r_owner) begin
                r_m1_rdata <= mem_rdata;
            end else begin
                r_m0_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = (r_state == ST_ACCESS) && r_we;
    assign grant     = (r_state == ST_IDLE) ? 2'b00 : {r_owner, ~r_owner};
    assign m0_ack    = (r_state == ST_RESP) && !r_owner;
    assign m1_ack    = (r_state == ST_RESP) && r_owner;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed timing checks, tie-break order, reset abort and
// concurrent random traffic scored against per-master expected-rdata queues.
module tb_mem_bus_arbiter;

  localparam int MAX_BURST = 4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant, dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd0, last_rd1;

  // memory stand-in: combinational read, write on the clock edge
  logic [31:0] tb_mem [16];
  logic [15:0] tb_written = '0;

  mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .grant(grant), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h1234_5678;
    return 32'hA000_0000 | (i << 8) | i;
  endfunction

  assign mem_rdata = tb_written[mem_addr[5:2]] ? tb_mem[mem_addr[5:2]] : init_word(int'(mem_addr[5:2]));

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr[5:2]]     <= mem_wdata;
      tb_written[mem_addr[5:2]] <= 1'b1;
    end
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every ack pops the expected rdata for that master
  always @(negedge clk) begin
    if (!reset) begin
      if (m0_ack) begin
        if (exp0_q.size() == 0) check("m0_unexpected_ack", 32'd1, 32'd0);
        else check("m0_rdata", m0_rdata, exp0_q.pop_front());
      end
      if (m1_ack) begin
        if (exp1_q.size() == 0) check("m1_unexpected_ack", 32'd1, 32'd0);
        else check("m1_rdata", m1_rdata, exp1_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic m0_txn(input logic we, input logic [3:0] idx, input logic [31:0] data);
    bit got = 0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = we; m0_addr = 32'h1000_0000 | {idx, 2'b00}; m0_wdata = data;
    if (we) begin
      ref_mem[idx] = data;
      exp0_q.push_back(last_rd0);
    end else begin
      last_rd0 = ref_mem[idx];
      exp0_q.push_back(last_rd0);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m0_ack) begin got = 1; break; end
    end
    if (!got) check("m0_ack_timeout", 32'd0, 32'd1);
    m0_req = 1'b0;
  endtask

  task automatic m1_txn(input logic we, input logic [3:0] idx, input logic [31:0] data);
    bit got = 0;
    @(negedge clk);
    m1_req = 1'b1; m1_we = we; m1_addr = 32'h1000_0000 | {idx, 2'b00}; m1_wdata = data;
    if (we) begin
      ref_mem[idx] = data;
      exp1_q.push_back(last_rd1);
    end else begin
      last_rd1 = ref_mem[idx];
      exp1_q.push_back(last_rd1);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m1_ack) begin got = 1; break; end
    end
    if (!got) check("m1_ack_timeout", 32'd0, 32'd1);
    m1_req = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    bit g1;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    last_rd0 = '0; last_rd1 = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_acks", {m1_ack, m0_ack}, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    @(negedge clk);

    // M0 read: address at N+1, ack and data at N+2
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000_0004;
    last_rd0 = 32'h1234_5678;
    exp0_q.push_back(32'h1234_5678);
    @(negedge clk);
    check("rd_state_access", dbg_state, ST_ACCESS);
    check("rd_mem_addr", mem_addr, 32'h1000_0004);
    check("rd_mem_we", mem_we, 0);
    check("rd_grant", grant, 2'b01);
    check("rd_no_early_ack", m0_ack, 0);
    @(negedge clk);
    check("rd_ack", m0_ack, 1);
    check("rd_rdata", m0_rdata, 32'h1234_5678);
    m0_req = 0;
    @(negedge clk);
    check("rd_grant_idle", grant, 2'b00);
    check("rd_ack_pulse", m0_ack, 0);

    // M1 write: mem_we for exactly one cycle, m1_rdata untouched
    m1_txn(1'b0, 4'd9, 32'h0);
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 32'h1000_0010; m1_wdata = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    exp1_q.push_back(last_rd1);
    @(negedge clk);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h1000_0010);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_grant", grant, 2'b10);
    @(negedge clk);
    check("wr_ack", m1_ack, 1);
    check("wr_mem_we_resp", mem_we, 0);
    check("wr_rdata_kept", m1_rdata, last_rd1);
    m1_req = 0; m1_we = 0;
    @(negedge clk);
    check("wr_grant_idle", grant, 2'b00);
    check("wr_landed", tb_mem[4], 32'hDEAD_BEEF);

    // both masters request continuously; last winner was M1
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g1 = (i % 2) == 1;
`else
      g1 = (i % (MAX_BURST + 1)) == MAX_BURST;
`endif
      if (g1) exp1_q.push_back(ref_mem[8]); else exp0_q.push_back(ref_mem[0]);
    end
    last_rd0 = ref_mem[0]; last_rd1 = ref_mem[8];
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000_0000;
    m1_req = 1; m1_we = 0; m1_addr = 32'h1000_0020;
    k = 0; cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dbg_state == ST_ACCESS && k < 10) begin
`ifdef ARB_ROUND_ROBIN_EN
        g1 = (k % 2) == 1;
`else
        g1 = (k % (MAX_BURST + 1)) == MAX_BURST;
`endif
        check($sformatf("burst_grant_%0d", k), grant, g1 ? 2'b10 : 2'b01);
        k++;
      end else if (dbg_state == ST_RESP && k == 10) begin
        m0_req = 0; m1_req = 0;
        break;
      end
    end
    m0_req = 0; m1_req = 0;
    check("burst_count", k, 10);
    check("burst_cycles", cyc, 29);

    // reset during ACCESS aborts the write without an ack
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 32'h1000_003C; m0_wdata = 32'h5555_AAAA;
    @(negedge clk);
    check("abort_pre_we", mem_we, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_mem_we", mem_we, 0);
    check("abort_grant", grant, 0);
    check("abort_state", dbg_state, ST_IDLE);
    m0_req = 0; m0_we = 0;
    @(negedge clk);
    reset = 1'b0;
    last_rd0 = '0; last_rd1 = '0;
    check("abort_m0_rdata", m0_rdata, 0);
    check("abort_m1_rdata", m1_rdata, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", m0_ack, 0);
    end
    m0_txn(1'b0, 4'd2, 32'h0);

    // M0 drops req during ACCESS: still acked
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000_000C;
    last_rd0 = ref_mem[3];
    exp0_q.push_back(last_rd0);
    @(negedge clk);
    m0_req = 0;
    @(negedge clk);
    check("drop_ack", m0_ack, 1);
    @(negedge clk);
    check("drop_grant", grant, 2'b00);

    // concurrent random traffic in disjoint address regions
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          m0_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), $urandom);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          m1_txn(1'($urandom_range(0, 1)), 4'($urandom_range(8, 14)), $urandom);
        end
      end
    join
    repeat (5) @(negedge clk);
    check("exp0_q_empty", exp0_q.size(), 0);
    check("exp1_q_empty", exp1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
